alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter BITS, default 8, meaning datapath and register width.
REQ-002 The block SHALL have parameter OPCODE, default 5, meaning ALU function-code width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rstN  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have these instruction ports: instrValid  in  1  instruction offered; instrReady  out  1  instruction accepted when both high; instrOp  in  OPCODE  operation; instrRd  in  2  destination register; instrRs1  in  2  source A register; instrRs2  in  2  source B register; instrImmSel  in  1  B operand from instrImm; instrImm  in  BITS  immediate.
REQ-005 The block SHALL have these ALU-drive ports: aluFunction  out  OPCODE  function code to the ALU; vectorA  out  BITS  operand A; vectorB  out  BITS  operand B; aluResult  in  BITS  combinational ALU result.
REQ-006 The block SHALL have these response ports: respValid  out  1  result available; respReady  in  1  result consumed; respData  out  BITS  result; respZero  out  1  result equals 0; respOverflow  out  1  signed overflow; respError  out  1  unsupported opcode.

Function
REQ-007 The block SHALL hold a 4 x BITS register file: two read ports, one write port.
REQ-008 The block SHALL implement FSM states IDLE, EXEC, MUL and RESP.
REQ-009 instrReady SHALL be 1 only in IDLE, and acceptance SHALL occur when instrValid and instrReady are both high on a rising edge.
REQ-010 On acceptance, the block SHALL latch op, rd, operand A = R[rs1], and operand B = (instrImmSel ? instrImm : R[rs2]).
REQ-011 On acceptance, the next state SHALL be EXEC for op in {0,1,2,3,4,11,12}, MUL for op 5, and RESP with respError=1 otherwise.
REQ-012 In EXEC, aluFunction SHALL equal the latched op, vectorA/vectorB SHALL equal the latched operands, and aluResult SHALL be captured at the end of the cycle.
REQ-013 In EXEC, the captured result SHALL be written to R[rd], and the next state SHALL be RESP.
REQ-014 Latency for ALU ops: acceptance at edge k SHALL give respValid=1 after edge k+1; for an error: after edge k.
REQ-015 MUL SHALL be a shift-add over exactly BITS cycles.
REQ-016 MUL SHALL set acc=0, mcand=A, mplier=B at acceptance.
REQ-017 Each MUL cycle SHALL drive aluFunction=0, vectorA=acc, vectorB=mcand, and SHALL load acc<=aluResult only if mplier[0]=1.
REQ-018 Each MUL cycle SHALL apply mcand<<=1 and mplier>>=1 internally.
REQ-019 After the last MUL cycle, acc SHALL be written to R[rd], and respValid=1 SHALL appear after edge k+BITS.
REQ-020 The MUL result SHALL be the low BITS bits only.
REQ-021 Outside EXEC/MUL, aluFunction, vectorA and vectorB SHALL be 0.
REQ-022 respZero SHALL be (respData==0).
REQ-023 respOverflow for op 0 SHALL be set when A and B signs are equal and the result sign differs.
REQ-024 respOverflow for op 1 SHALL be set when A and B signs differ and the result sign differs from A.
REQ-025 respOverflow SHALL be 0 for all other ops, including MUL.
REQ-026 The error response SHALL have respData=0 and SHALL perform no register write.
REQ-027 In RESP, respValid and all resp* outputs SHALL stay stable until respReady=1.
REQ-028 In RESP, respValid and respReady both high SHALL return the FSM to IDLE with respValid=0 on the next cycle.
REQ-029 rd equal to rs1 or rs2 SHALL be legal, since operands are latched before the write.
REQ-030 An instruction offered outside IDLE SHALL be ignored until instrReady=1.

Reset
REQ-031 On rstN=0, the block SHALL asynchronously enter IDLE and clear all registers R0-R3 and acc/mcand/mplier.
REQ-032 On rstN=0, instrReady, respValid, respZero, respOverflow and respError SHALL be 0, and respData, aluFunction, vectorA and vectorB SHALL be 0.
REQ-033 instrReady SHALL rise on the first clk edge after rstN deasserts.
REQ-034 Reset during EXEC/MUL/RESP SHALL abort the operation, with no write and no response.

Structure
REQ-035 A shared package SHALL hold the opcode constants (ADD=0, SUB=1, XOR=2, AND=3, OR=4, MUL=5, SHL=11, SHR=12) and the FSM state type.
REQ-036 The register file SHALL be a sub-module alu_regfile (4 x BITS, 2 read, 1 write, async reset).

Verification
REQ-037 The bench SHALL check: after reset, op0 rd1 rs1=0 imm 8'h05 -> respData 8'h05, zero 0, respValid after edge k+1.
REQ-038 The bench SHALL check: op1 rd2 rs1=1 rs2=1 -> respData 8'h00, respZero 1, R2=0.
REQ-039 The bench SHALL check: R1=8'h7F, op0 rd3 rs1=1 imm 8'h01 -> respData 8'h80, respOverflow 1.
REQ-040 The bench SHALL check: R1=8'h0C, op5 rs1=1 imm 8'h0B -> respData 8'h84, respValid after edge k+8, with aluFunction 0 throughout MUL.
REQ-041 The bench SHALL check: op 5'd7 -> respError 1, respData 0, respValid after edge k, register file unchanged.
REQ-042 The bench SHALL check: respReady held low 5 cycles -> resp* stable and instrReady 0.
REQ-043 The bench SHALL check: rstN pulsed mid-MUL -> IDLE, R0-R3=0, no response.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared opcode constants, FSM state type and opcode classification helper.
package alu_sequencer_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_XOR = 2;
  localparam int OP_AND = 3;
  localparam int OP_OR  = 4;
  localparam int OP_MUL = 5;
  localparam int OP_SHL = 11;
  localparam int OP_SHR = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } seqState_t;

  // Single-cycle ALU operations executed in EXEC.
  function automatic logic isAluOp(input int op);
    return (op inside {OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR, OP_SHL, OP_SHR});
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Four-entry register file: two combinational read ports, one write port.
module alu_regfile
  import alu_sequencer_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic [1:0]      rdAddrA,
  input  logic [1:0]      rdAddrB,
  output logic [BITS-1:0] rdDataA,
  output logic [BITS-1:0] rdDataB,
  input  logic            wrEn,
  input  logic [1:0]      wrAddr,
  input  logic [BITS-1:0] wrData
);

  logic [BITS-1:0] regs [4];

  // Register storage, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (wrEn) begin
      regs[wrAddr] <= wrData;
    end
  end

  assign rdDataA = regs[rdAddrA];
  assign rdDataB = regs[rdAddrB];

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer driving an external combinational ALU, with a
// shift-add multiplier built on the ALU adder and a ready/valid response.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int OPCODE = 5
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              instrValid,
  output logic              instrReady,
  input  logic [OPCODE-1:0] instrOp,
  input  logic [1:0]        instrRd,
  input  logic [1:0]        instrRs1,
  input  logic [1:0]        instrRs2,
  input  logic              instrImmSel,
  input  logic [BITS-1:0]   instrImm,
  output logic [OPCODE-1:0] aluFunction,
  output logic [BITS-1:0]   vectorA,
  output logic [BITS-1:0]   vectorB,
  input  logic [BITS-1:0]   aluResult,
  output logic              respValid,
  input  logic              respReady,
  output logic [BITS-1:0]   respData,
  output logic              respZero,
  output logic              respOverflow,
  output logic              respError
);

  localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(BITS - 1);

  seqState_t              state, stateNext;
  logic                   started;
  logic [OPCODE-1:0]      opL;
  logic [1:0]             rdL;
  logic signed [BITS-1:0] opA, opB;
  logic [BITS-1:0]        acc, mcand, mplier, accNext, operandB;
  logic [CNT_W-1:0]       mulCnt;
  logic [BITS-1:0]        rdDataA, rdDataB, wrData;
  logic                   wrEn, accept, mulLast;

  // Signed overflow flag; only add and subtract can overflow.
  function automatic logic addSubOverflow(input logic [OPCODE-1:0] op,
                                          input logic signed [BITS-1:0] a,
                                          input logic signed [BITS-1:0] b,
                                          input logic signed [BITS-1:0] r);
    logic sa, sb, sr;
    sa = (a < 0);
    sb = (b < 0);
    sr = (r < 0);
    if (op == OPCODE'(OP_ADD)) return (sa == sb) && (sr != sa);
    if (op == OPCODE'(OP_SUB)) return (sa != sb) && (sr != sa);
    return 1'b0;
  endfunction

  alu_regfile #(.BITS(BITS)) uRegfile (
    .clk     (clk),
    .rstN    (rstN),
    .rdAddrA (instrRs1),
    .rdAddrB (instrRs2),
    .rdDataA (rdDataA),
    .rdDataB (rdDataB),
    .wrEn    (wrEn),
    .wrAddr  (rdL),
    .wrData  (wrData)
  );

  // Ready is held off until the first edge after reset release.
  assign instrReady = started && (state == IDLE);
  assign respValid  = (state == RESP);
  assign accept     = instrReady && instrValid;
  assign operandB   = instrImmSel ? instrImm : rdDataB;
  assign mulLast    = (mulCnt == MUL_LAST);
  assign accNext    = mplier[0] ? aluResult : acc;

  // State register and post-reset start flag.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= IDLE;
      started <= 1'b0;
    end else begin
      state   <= stateNext;
      started <= 1'b1;
    end
  end

  // Next-state decode, ALU drive and register-file write strobe.
  always_comb begin
    stateNext   = state;
    aluFunction = '0;
    vectorA     = '0;
    vectorB     = '0;
    wrEn        = 1'b0;
    wrData      = aluResult;
    case (state)
      IDLE: begin
        if (accept) begin
          if (isAluOp(int'(instrOp)))           stateNext = EXEC;
          else if (instrOp == OPCODE'(OP_MUL))  stateNext = MUL;
          else                                  stateNext = RESP;
        end
      end
      EXEC: begin
        aluFunction = opL;
        vectorA     = opA;
        vectorB     = opB;
        wrEn        = 1'b1;
        stateNext   = RESP;
      end
      MUL: begin
        // ALU function 0 (add) accumulates the shifted multiplicand.
        vectorA = acc;
        vectorB = mcand;
        if (mulLast) begin
          wrEn      = 1'b1;
          wrData    = accNext;
          stateNext = RESP;
        end
      end
      RESP: begin
        if (respReady) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Operand latching, multiplier iteration and response registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      opL          <= '0;
      rdL          <= '0;
      opA          <= '0;
      opB          <= '0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      mulCnt       <= '0;
      respData     <= '0;
      respZero     <= 1'b0;
      respOverflow <= 1'b0;
      respError    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opL    <= instrOp;
            rdL    <= instrRd;
            opA    <= rdDataA;
            opB    <= operandB;
            acc    <= '0;
            mcand  <= rdDataA;
            mplier <= operandB;
            mulCnt <= '0;
            if (stateNext == RESP) begin
              respData     <= '0;
              respZero     <= 1'b1;
              respOverflow <= 1'b0;
              respError    <= 1'b1;
            end
          end
        end
        EXEC: begin
          respData     <= aluResult;
          respZero     <= (aluResult == '0);
          respOverflow <= addSubOverflow(opL, opA, opB, aluResult);
          respError    <= 1'b0;
        end
        MUL: begin
          acc    <= accNext;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          mulCnt <= mulCnt + 1'b1;
          if (mulLast) begin
            respData     <= accNext;
            respZero     <= (accNext == '0);
            respOverflow <= 1'b0;
            respError    <= 1'b0;
          end
        end
        RESP: begin
          if (respReady) begin
            respData     <= '0;
            respZero     <= 1'b0;
            respOverflow <= 1'b0;
            respError    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU attached.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int BITS   = 8;
  localparam int OPCODE = 5;

  logic              clk = 1'b0;
  logic              rstN;
  logic              instrValid;
  logic              instrReady;
  logic [OPCODE-1:0] instrOp;
  logic [1:0]        instrRd, instrRs1, instrRs2;
  logic              instrImmSel;
  logic [BITS-1:0]   instrImm;
  logic [OPCODE-1:0] aluFunction;
  logic [BITS-1:0]   vectorA, vectorB, aluResult;
  logic              respValid, respReady;
  logic [BITS-1:0]   respData;
  logic              respZero, respOverflow, respError;

  typedef struct {
    logic [7:0] data;
    logic       zero;
    logic       ovf;
    logic       err;
    int         lat;
    logic [4:0] op;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] mdl[4];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.BITS(BITS), .OPCODE(OPCODE)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .instrValid   (instrValid),
    .instrReady   (instrReady),
    .instrOp      (instrOp),
    .instrRd      (instrRd),
    .instrRs1     (instrRs1),
    .instrRs2     (instrRs2),
    .instrImmSel  (instrImmSel),
    .instrImm     (instrImm),
    .aluFunction  (aluFunction),
    .vectorA      (vectorA),
    .vectorB      (vectorB),
    .aluResult    (aluResult),
    .respValid    (respValid),
    .respReady    (respReady),
    .respData     (respData),
    .respZero     (respZero),
    .respOverflow (respOverflow),
    .respError    (respError)
  );

  // Behavioural combinational ALU.
  always_comb begin
    case (aluFunction)
      5'd0:    aluResult = vectorA + vectorB;
      5'd1:    aluResult = vectorA - vectorB;
      5'd2:    aluResult = vectorA ^ vectorB;
      5'd3:    aluResult = vectorA & vectorB;
      5'd4:    aluResult = vectorA | vectorB;
      5'd11:   aluResult = vectorA << vectorB[2:0];
      5'd12:   aluResult = vectorA >> vectorB[2:0];
      default: aluResult = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compute expectation, push it, then offer the instruction until accepted.
  task automatic issue(input logic [4:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic immSel, input logic [7:0] imm);
    exp_t        e;
    logic [7:0]  a, b, r;
    logic [15:0] p;
    int          guard = 0;
    a     = mdl[rs1];
    b     = immSel ? imm : mdl[rs2];
    e.err = 1'b0;
    e.ovf = 1'b0;
    e.lat = 1;
    e.op  = op;
    case (op)
      5'd0:  begin r = a + b; e.ovf = (a[7] == b[7]) && (r[7] != a[7]); end
      5'd1:  begin r = a - b; e.ovf = (a[7] != b[7]) && (r[7] != a[7]); end
      5'd2:  r = a ^ b;
      5'd3:  r = a & b;
      5'd4:  r = a | b;
      5'd5:  begin p = a * b; r = p[7:0]; e.lat = BITS; end
      5'd11: r = a << b[2:0];
      5'd12: r = a >> b[2:0];
      default: begin r = 8'h00; e.err = 1'b1; e.lat = 0; end
    endcase
    e.data = r;
    e.zero = (r == 8'h00);
    if (!e.err) mdl[rd] = r;
    sbq.push_back(e);
    @(negedge clk);
    instrOp     = op;
    instrRd     = rd;
    instrRs1    = rs1;
    instrRs2    = rs2;
    instrImmSel = immSel;
    instrImm    = imm;
    instrValid  = 1'b1;
    while (!instrReady && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!instrReady) chk("acceptTimeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 instrValid = 1'b0;
  endtask

  // Wait for the response, compare against the scoreboard, optionally stall.
  task automatic collect(input int hold);
    exp_t e;
    int   lat = 0;
    logic funcOk = 1'b1;
    e = sbq.pop_front();
    if (!e.err && e.op != 5'd5) chk("execFunc", aluFunction, e.op);
    while (!respValid && lat < 60) begin
      if (e.op == 5'd5 && aluFunction !== 5'd0) funcOk = 1'b0;
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", lat, e.lat);
    if (e.op == 5'd5) chk("mulFunc", funcOk, 1'b1);
    chk("respData", respData, e.data);
    chk("respZero", respZero, e.zero);
    chk("respOvf", respOverflow, e.ovf);
    chk("respErr", respError, e.err);
    for (int i = 0; i < hold; i++) begin
      instrValid = 1'b1;
      instrOp    = 5'd2;
      @(posedge clk);
      #1;
      chk("holdValid", respValid, 1'b1);
      chk("holdData", respData, e.data);
      chk("holdFlags", {respZero, respOverflow, respError}, {e.zero, e.ovf, e.err});
      chk("holdReady", instrReady, 1'b0);
    end
    instrValid = 1'b0;
    respReady  = 1'b1;
    @(posedge clk);
    #1 respReady = 1'b0;
    chk("respDrop", respValid, 1'b0);
    chk("readyBack", instrReady, 1'b1);
  endtask

  task automatic readReg(input logic [1:0] r);
    issue(5'd4, r, r, 2'd0, 1'b1, 8'h00);
    collect(0);
  endtask

  initial begin
    logic seen;
    rstN        = 1'b0;
    instrValid  = 1'b0;
    instrOp     = '0;
    instrRd     = '0;
    instrRs1    = '0;
    instrRs2    = '0;
    instrImmSel = 1'b0;
    instrImm    = '0;
    respReady   = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    chk("rstReady", instrReady, 1'b0);
    chk("rstResp", {respValid, respZero, respOverflow, respError}, 4'b0000);
    chk("rstData", respData, 8'h00);
    chk("rstAlu", {aluFunction, vectorA, vectorB}, 21'd0);
    @(negedge clk) rstN = 1'b1;
    @(posedge clk);
    #1 chk("readyRise", instrReady, 1'b1);

    // ADD immediate into R1.
    issue(5'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05); collect(0);
    // SUB R1-R1 into R2 gives zero.
    issue(5'd1, 2'd2, 2'd1, 2'd1, 1'b0, 8'h00); collect(0);
    readReg(2'd2);
    // Signed add overflow 7F+1.
    issue(5'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7F); collect(0);
    issue(5'd0, 2'd3, 2'd1, 2'd0, 1'b1, 8'h01); collect(0);
    // Multiply 0C*0B via shift-add.
    issue(5'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h0C); collect(0);
    issue(5'd5, 2'd2, 2'd1, 2'd0, 1'b1, 8'h0B); collect(0);
    // Unsupported opcode leaves registers untouched.
    issue(5'd7, 2'd1, 2'd1, 2'd2, 1'b1, 8'h33); collect(0);
    for (int r = 0; r < 4; r++) readReg(2'(r));
    // Signed subtract overflow 80-1, other ops, register-sourced multiply.
    issue(5'd1, 2'd0, 2'd3, 2'd0, 1'b1, 8'h01); collect(0);
    issue(5'd2, 2'd1, 2'd1, 2'd2, 1'b0, 8'h00); collect(0);
    issue(5'd3, 2'd2, 2'd2, 2'd0, 1'b0, 8'h00); collect(0);
    issue(5'd11, 2'd3, 2'd1, 2'd0, 1'b1, 8'h03); collect(0);
    issue(5'd5, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00); collect(0);
    // Response stalled for five cycles with another instruction offered.
    issue(5'd12, 2'd2, 2'd3, 2'd0, 1'b1, 8'h02); collect(5);
    for (int r = 0; r < 4; r++) readReg(2'(r));

    // Reset in the middle of a multiply aborts it.
    issue(5'd5, 2'd2, 2'd1, 2'd3, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    chk("abortReady", instrReady, 1'b0);
    chk("abortValid", respValid, 1'b0);
    chk("abortFunc", aluFunction, 5'd0);
    sbq.delete();
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    @(negedge clk) rstN = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (respValid) seen = 1'b1;
    end
    chk("noResp", seen, 1'b0);
    for (int r = 0; r < 4; r++) readReg(2'(r));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
